// File: rtl/dds_sweep_sequencer.sv
// rtl/dds_sweep_sequencer.sv - frequency-sweep scheduler driving the DDS tuning word
// Steps freq from START_WORD to STOP_WORD, holding each word DWELL clocks (single/sawtooth/triangle).
module dds_sweep_sequencer #(
  parameter logic [31:0] START_WORD = 32'd5368700,
  parameter logic [31:0] STOP_WORD  = 32'd53687000,
  parameter logic [31:0] STEP_WORD  = 32'd1073740,
  parameter int unsigned DWELL      = 40000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [1:0]  mode,
  output logic [31:0] freq,
  output logic        busy,
  output logic        step_strobe,
  output logic        done
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_DOWN} state_t;

  state_t        state;
  logic [1:0]    mode_r;
  logic [CW-1:0] cnt;
  logic          dwell_end;
  logic [32:0]   up_sum;
  logic [31:0]   up_next;
  logic signed [33:0] dn_diff;
  logic [31:0]   dn_next;

  // Wide arithmetic so the clamp comparisons never see a wrapped value.
  assign up_sum    = {1'b0, freq} + {1'b0, STEP_WORD};
  assign up_next   = (up_sum > {1'b0, STOP_WORD}) ? STOP_WORD : up_sum[31:0];
  assign dn_diff   = $signed({2'b00, freq}) - $signed({2'b00, STEP_WORD});
  assign dn_next   = (dn_diff < $signed({2'b00, START_WORD})) ? START_WORD : dn_diff[31:0];
  assign dwell_end = (cnt == DWELL_LAST);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      mode_r      <= 2'd0;
      cnt         <= '0;
      freq        <= START_WORD;
      step_strobe <= 1'b0;
      done        <= 1'b0;
    end else begin
      step_strobe <= 1'b0;
      done        <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            freq        <= START_WORD;
            mode_r      <= mode;
            cnt         <= '0;
            state       <= S_UP;
            step_strobe <= 1'b1;
          end
        end
        S_UP: begin
          if (abort) begin
            state <= S_IDLE;
            freq  <= START_WORD;
            cnt   <= '0;
          end else if (dwell_end) begin
            cnt <= '0;
            if (freq != STOP_WORD) begin
              freq        <= up_next;
              step_strobe <= 1'b1;
            end else begin
              case (mode_r)
                2'd1: begin
                  freq        <= START_WORD;
                  step_strobe <= 1'b1;
                end
                2'd2: begin
                  state       <= S_DOWN;
                  freq        <= dn_next;
                  step_strobe <= 1'b1;
                end
                default: begin
                  state <= S_IDLE;
                  done  <= 1'b1;
                end
              endcase
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DOWN: begin
          if (abort) begin
            state <= S_IDLE;
            freq  <= START_WORD;
            cnt   <= '0;
          end else if (dwell_end) begin
            cnt         <= '0;
            step_strobe <= 1'b1;
            if (freq != START_WORD) begin
              freq <= dn_next;
            end else begin
              state <= S_UP;
              freq  <= up_next;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
